ram_lane_streamer: RTL

Read-side sequencer placed directly downstream of the dual-port `dffram` weight/activation store. It walks a contiguous (wrapping) address window on the RAM's second read port and unpacks each DWIDTH-bit word into LANES byte lanes. It presents those lanes to the systolic array with diagonal skew: lane k is delayed k cycles. It owns `adr_r` and consumes `dat_o2`; the RAM write port stays with the upstream loader.

---
 rtl/etpu_pkg.sv | 22 ++
 rtl/skew_line.sv | 42 ++++
 rtl/ram_lane_streamer.sv | 115 +++++++++++
 3 files changed

// File: rtl/etpu_pkg.sv
// Shared types and helpers for the eTPU datapath blocks.
//   state_e   : read-side sequencer states
//   LANE_W    : byte-lane width
//   lane_byte : extract byte lane k from a (zero-extended) RAM word
package etpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned LANE_W     = 8;
  localparam int unsigned MAX_WORD_W = 256;

  // Callers zero-extend their word to MAX_WORD_W so one helper serves any DWIDTH.
  function automatic logic [LANE_W-1:0] lane_byte(input logic [MAX_WORD_W-1:0] word,
                                                  input int unsigned k);
    return LANE_W'(word >> (k * LANE_W));
  endfunction

endpackage

// File: rtl/skew_line.sv
// Valid+data shift chain of DEPTH registers, used to skew one byte lane.
//   clk, rst_n : clock, async active-low reset
//   in_vld     : input valid
//   in_dat     : input byte (stored as zero when in_vld is low)
//   out_vld    : valid after DEPTH cycles
//   out_dat    : data after DEPTH cycles
module skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  localparam int unsigned CW = DEPTH * W;

  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] dat_q;
  logic [W-1:0]            dat_in;

  // Masking at the entry keeps every invalid slot zero all the way down the chain.
  assign dat_in = in_vld ? in_dat : '0;

  // Shift toward the MSB; the truncating cast drops the oldest entry and works for DEPTH=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= DEPTH'({vld_q, in_vld});
      dat_q <= CW'({dat_q, dat_in});
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/ram_lane_streamer.sv
// Read-side sequencer for the dffram second read port: walks a wrapping
// address window, unpacks each word into byte lanes and skews lane k by k cycles.
//   clk, rst_n : clock, async active-low reset
//   start      : launch request (ignored while busy)
//   base, len  : first address / word count (len=0 ignored)
//   adr_r      : RAM read address (registered)
//   ram_dat    : RAM read data, one cycle after adr_r
//   lane_o     : skewed byte lanes, zero when invalid
//   lane_vld   : per-lane valid
//   busy, done : run in progress / one-cycle completion pulse
module ram_lane_streamer
  import etpu_pkg::*;
#(
  parameter int unsigned DWIDTH = 24,
  parameter int unsigned AWIDTH = 6,
  parameter int unsigned LANES  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH:0]   len,
  output logic [AWIDTH-1:0] adr_r,
  input  logic [DWIDTH-1:0] ram_dat,
  output logic [DWIDTH-1:0] lane_o,
  output logic [LANES-1:0]  lane_vld,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LEN_W = AWIDTH + 1;
  localparam int unsigned DRN_W = $clog2(LANES + 1);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] adr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              busy_d, done_d;
  logic              rd_vld_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      adr_r    <= '0;
      rem_q    <= '0;
      drn_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_r    <= adr_d;
      rem_q    <= rem_d;
      drn_q    <= drn_d;
      busy     <= busy_d;
      done     <= done_d;
      // Marks the cycle in which ram_dat answers an address issued in READ.
      rd_vld_q <= (state_q == ST_READ);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_r;
    rem_d   = rem_q;
    drn_d   = drn_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          state_d = ST_READ;
          adr_d   = base;
          rem_d   = len;
        end
      end
      ST_READ: begin
        adr_d = adr_r + AWIDTH'(1);
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end
      end
      ST_DRAIN: begin
        drn_d = drn_q + DRN_W'(1);
        // Last word reaches the deepest lane one cycle after this point.
        if (drn_q == DRN_W'(LANES - 1)) done_d = 1'b1;
        if (drn_q == DRN_W'(LANES)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Per-lane skew chains: lane k is k+1 registers deep.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LANE_W-1:0] lane_in;
    assign lane_in = lane_byte(MAX_WORD_W'(ram_dat), k);

    skew_line #(
      .DEPTH(k + 1),
      .W    (LANE_W)
    ) u_skew (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_vld (rd_vld_q),
      .in_dat (lane_in),
      .out_vld(lane_vld[k]),
      .out_dat(lane_o[k*LANE_W +: LANE_W])
    );
  end

endmodule
